// File: rtl/nibble_serial_subtractor_pkg.sv
//------------------------------------------------------------------------------
// Module   : sub_pkg
// Purpose  : Shared types and helpers for the nibble-serial subtractor.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package sub_pkg;

    // Width of one processing slice.
    localparam int NIB_W = 4;

    // Control states of the serial subtractor.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Ceiling log2, never less than 1 so a counter always has at least one bit.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/nibble_serial_subtractor_slice.sv
//------------------------------------------------------------------------------
// Module   : borrow_look_ahead_slice
// Purpose  : Combinational 4-bit subtract slice, {bout,d} = a - b - bin,
//            with all internal borrows computed by lookahead.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module borrow_look_ahead_slice
    import sub_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             bin,
    output logic [NIB_W-1:0] d,
    output logic             bout
);

    logic [NIB_W-1:0] w_g;   // bit generates a borrow
    logic [NIB_W-1:0] w_p;   // bit propagates an incoming borrow
    logic [NIB_W:0]   w_c;   // borrow into each bit, w_c[4] is the slice borrow-out

    assign w_g = ~a & b;
    assign w_p = ~(a ^ b);

    // Flattened lookahead equations: every borrow depends only on g/p and bin.
    always_comb begin
        w_c[0] = bin;
        w_c[1] = w_g[0] | (w_p[0] & bin);
        w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & bin);
        w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
               | (w_p[2] & w_p[1] & w_p[0] & bin);
        w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
               | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & bin);
    end

    assign d    = a ^ b ^ w_c[NIB_W-1:0];
    assign bout = w_c[NIB_W];

endmodule

`default_nettype wire

// File: rtl/nibble_serial_subtractor.sv
//------------------------------------------------------------------------------
// Module   : nibble_serial_subtractor
// Purpose  : Multi-cycle unsigned subtractor, diff = a - b - bin, one nibble
//            per clock LSB first, behind valid/ready handshakes.
// Options  : SIGNED_OVERFLOW_EN adds a registered two's-complement ovf output.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module nibble_serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
`ifdef SIGNED_OVERFLOW_EN
    output logic             ovf,
`endif
    output logic             zero
);

    localparam int NIB   = WIDTH / NIB_W;
    localparam int IDX_W = clog2(NIB);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    generate
        if ((WIDTH % NIB_W) != 0 || WIDTH < NIB_W) begin : g_bad_width
            $error("nibble_serial_subtractor: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    state_e           state_q,  state_d;
    logic [IDX_W-1:0] idx_q,    idx_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic             brw_q,    brw_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] diff_q,   diff_d;
    logic             bout_q,   bout_d;
    logic             zero_q,   zero_d;
`ifdef SIGNED_OVERFLOW_EN
    logic             ovf_q,    ovf_d;
`endif

    logic [IDX_W+1:0] w_bit_idx;
    logic [NIB_W-1:0] w_slice_d;
    logic             w_slice_bout;

    // Bit offset of the nibble currently being processed.
    assign w_bit_idx = {idx_q, 2'b00};

    borrow_look_ahead_slice u_slice (
        .a    (a_q[w_bit_idx +: NIB_W]),
        .b    (b_q[w_bit_idx +: NIB_W]),
        .bin  (brw_q),
        .d    (w_slice_d),
        .bout (w_slice_bout)
    );

    // Next-state and datapath: capture in IDLE, one nibble per RUN cycle,
    // publish the completed shadow result only when entering DONE.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        brw_d    = brw_q;
        shadow_d = shadow_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        zero_d   = zero_q;
`ifdef SIGNED_OVERFLOW_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    brw_d    = bin;
                    idx_d    = '0;
                    shadow_d = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                shadow_d[w_bit_idx +: NIB_W] = w_slice_d;
                brw_d = w_slice_bout;
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    diff_d  = shadow_d;
                    bout_d  = w_slice_bout;
                    zero_d  = (shadow_d == '0);
`ifdef SIGNED_OVERFLOW_EN
                    ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                              (shadow_d[WIDTH-1] != a_q[WIDTH-1]);
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            brw_q    <= 1'b0;
            shadow_q <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            zero_q   <= 1'b0;
`ifdef SIGNED_OVERFLOW_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            brw_q    <= brw_d;
            shadow_q <= shadow_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            zero_q   <= zero_d;
`ifdef SIGNED_OVERFLOW_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign zero      = zero_q;
`ifdef SIGNED_OVERFLOW_EN
    assign ovf       = ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_subtractor.sv
//------------------------------------------------------------------------------
// Module   : tb_nibble_serial_subtractor
// Purpose  : Self-checking bench for nibble_serial_subtractor and its slice.
// Options  : SIGNED_OVERFLOW_EN enables the ovf checks.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_nibble_serial_subtractor;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        bout;
    logic        zero;
`ifdef SIGNED_OVERFLOW_EN
    logic        ovf;
`endif

    logic [3:0]  sa;
    logic [3:0]  sb;
    logic        sbin;
    logic [3:0]  sd;
    logic        sbo;

    int checks = 0;
    int errors = 0;

    nibble_serial_subtractor #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
`ifdef SIGNED_OVERFLOW_EN
        .ovf       (ovf),
`endif
        .zero      (zero)
    );

    borrow_look_ahead_slice u_slice_ut (
        .a    (sa),
        .b    (sb),
        .bin  (sbin),
        .d    (sd),
        .bout (sbo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launch one operation and wait for out_valid; leaves the result pending.
    task automatic start_op(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                            input logic tbin, input logic [15:0] ediff, input logic ebout,
                            input logic ezero, input logic eovf);
        int cnt;
        @(negedge clk);
        a = ta; b = tb; bin = tbin; in_valid = 1'b1;
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = $urandom; b = $urandom; bin = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check({tag, "_latency"}, cnt, 32'd4);
        check({tag, "_diff"}, {16'd0, diff}, {16'd0, ediff});
        check({tag, "_bout"}, {31'd0, bout}, {31'd0, ebout});
        check({tag, "_zero"}, {31'd0, zero}, {31'd0, ezero});
`ifdef SIGNED_OVERFLOW_EN
        check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eovf});
`else
        if (eovf) begin end
`endif
    endtask

    // Complete the output handshake and confirm the return to IDLE.
    task automatic finish_op(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        logic [16:0] t;
        logic [15:0] ra, rb, rd;
        logic        rbin, rovf;
        logic [4:0]  st;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; bin = 1'b0;
        sa = '0; sb = '0; sbin = 1'b0;

        // Exhaustive slice check against plain 5-bit arithmetic.
        for (int i = 0; i < 512; i++) begin
            {sbin, sa, sb} = i[8:0];
            #1;
            st = {1'b0, sa} - {1'b0, sb} - {4'd0, sbin};
            check("slice", {27'd0, sbo, sd}, {27'd0, st});
        end

        repeat (2) @(negedge clk);
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_diff",      {16'd0, diff},      32'd0);
        check("rst_bout",      {31'd0, bout},      32'd0);
        check("rst_zero",      {31'd0, zero},      32'd0);
        rst_n = 1'b1;

        // Directed operations.
        start_op("basic", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
        finish_op("basic");
        start_op("uflow", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        finish_op("uflow");
        start_op("eqbin", 16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        finish_op("eqbin");
        start_op("zero", 16'h00FF, 16'h00FF, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        finish_op("zero");
        start_op("ovf_neg", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1);
        finish_op("ovf_neg");
        start_op("ovf_pos", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1);
        finish_op("ovf_pos");
        start_op("no_ovf", 16'h0003, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
        finish_op("no_ovf");

        // Backpressure: result held, new requests ignored.
        start_op("bp", 16'h5678, 16'h1234, 1'b0, 16'h4444, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1; a = 16'h0000; b = 16'h0000;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_diff",  {16'd0, diff},      32'h4444);
            check("bp_bout",  {31'd0, bout},      32'd0);
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_ready", {31'd0, in_ready},  32'd0);
        end
        finish_op("bp");
        in_valid = 1'b0;
        check("bp_hold_diff", {16'd0, diff}, 32'h4444);
        @(negedge clk);
        check("bp_no_accept", {31'd0, in_ready}, 32'd1);

        // Reset in the middle of a run.
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0001; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_diff",  {16'd0, diff},      32'd0);
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_ready", {31'd0, in_ready},  32'd1);
        check("mid_rst_bout",  {31'd0, bout},      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        start_op("post_rst", 16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0, 1'b0);
        finish_op("post_rst");

        // Random operations with random gaps, checked against arithmetic.
        for (int n = 0; n < 200; n++) begin
            ra = 16'($urandom); rb = 16'($urandom); rbin = 1'($urandom);
            if (n % 17 == 0) rb = ra;
            t = {1'b0, ra} - {1'b0, rb} - {16'd0, rbin};
            rd = t[15:0];
            rovf = (ra[15] != rb[15]) && (rd[15] != ra[15]);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            start_op("rand", ra, rb, rbin, rd, t[16], (rd == 16'd0), rovf);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            finish_op("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
